// File: rtl/fp_norm_round_pipe_if.sv
// Handshake bundle for fp_norm_round_pipe.
// The master side feeds products and consumes results. The slave side is the pipeline.
interface fp_norm_round_pipe_if #(
  parameter int MW = 23,
  parameter int EW = 8
);
  localparam int PW = 2 * MW + 2;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [PW-1:0]     in_prod;
  logic [EW+1:0]     in_exp;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EW-1:0]     out_exp;
  logic [MW-1:0]     out_frac;
  logic              out_ovf;
  logic              out_unf;
  logic              out_inx;

  modport master (
    output in_valid, in_sign, in_prod, in_exp, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac, out_ovf, out_unf, out_inx
  );

  modport slave (
    input  in_valid, in_sign, in_prod, in_exp, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac, out_ovf, out_unf, out_inx
  );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalize / round / range-check pipeline for the FP multiplier.
// Stage 1 captures the raw product. Stage 2 registers the packed result and its flags.
// Optional feature macro NORM_RNE_EN:
//   - defined: round-to-nearest-even.
//   - undefined: truncation. The exponent carry path is then idle.
module fp_norm_round_pipe #(
  parameter int MW = 23,
  parameter int EW = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 en,
  fp_norm_round_pipe_if.slave  bus
);
  localparam int PW = 2 * MW + 2;
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic                 adv1;
  logic                 adv2;

  logic                 s1Valid_q;
  logic                 s1Sign_q;
  logic [PW-1:0]        s1Prod_q;
  logic signed [XW-1:0] s1Exp_q;

  logic                 s2Valid_q;
  logic                 outSign_q;
  logic [EW-1:0]        outExp_q;
  logic [MW-1:0]        outFrac_q;
  logic                 outOvf_q;
  logic                 outUnf_q;
  logic                 outInx_q;

  logic [PW-2:0]        norm;
  logic [MW-1:0]        fracN;
  logic                 guard;
  logic                 sticky;
  logic                 roundUp;
  logic                 carry;
  logic [MW-1:0]        fracR;
  logic signed [XW-1:0] expN;
  logic signed [XW-1:0] expR;

  logic                 outSign_d;
  logic [EW-1:0]        outExp_d;
  logic [MW-1:0]        outFrac_d;
  logic                 outOvf_d;
  logic                 outUnf_d;
  logic                 outInx_d;

  // Pipeline advance conditions. Stage 2 moves when empty or drained. Stage 1 moves when empty or stage 2 moves.
  always_comb begin
    adv2 = en & (~s2Valid_q | bus.out_ready);
    adv1 = en & (~s1Valid_q | adv2);
  end

  assign bus.in_ready  = adv1 & ~arst;
  assign bus.out_valid = s2Valid_q;
  assign bus.out_sign  = outSign_q;
  assign bus.out_exp   = outExp_q;
  assign bus.out_frac  = outFrac_q;
  assign bus.out_ovf   = outOvf_q;
  assign bus.out_unf   = outUnf_q;
  assign bus.out_inx   = outInx_q;

  // Normalize, round and range-check the stage-1 product into the next result word.
  always_comb begin
    // Left-align the product so the hidden bit always sits just above the fraction field.
    norm   = s1Prod_q[PW-1] ? s1Prod_q[PW-2:0] : {s1Prod_q[PW-3:0], 1'b0};
    fracN  = norm[PW-2 -: MW];
    guard  = norm[PW-2-MW];
    sticky = |norm[PW-3-MW:0];
    expN   = s1Exp_q + $signed({{(XW-1){1'b0}}, s1Prod_q[PW-1]});
`ifdef NORM_RNE_EN
    roundUp = guard & (sticky | fracN[0]);
`else
    roundUp = 1'b0;
`endif
    {carry, fracR} = {1'b0, fracN} + {{MW{1'b0}}, roundUp};
    expR = expN + $signed({{(XW-1){1'b0}}, carry});

    outSign_d = s1Sign_q;
    outExp_d  = '0;
    outFrac_d = '0;
    outOvf_d  = 1'b0;
    outUnf_d  = 1'b0;
    outInx_d  = 1'b0;
    if (s1Prod_q == '0) begin
      outExp_d = '0;
    end else if (expR >= EXP_MAX) begin
      outExp_d = '1;
      outOvf_d = 1'b1;
      outInx_d = 1'b1;
    end else if (expR <= EXP_ZERO) begin
      outUnf_d = 1'b1;
      outInx_d = 1'b1;
    end else begin
      outExp_d  = expR[EW-1:0];
      outFrac_d = fracR;
      outInx_d  = guard | sticky;
    end
  end

  // Stage 1 captures an accepted beat. An empty slot is left behind when stage 2 takes the beat and nothing new arrives.
  always_ff @(posedge clk) begin
    if (arst) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Prod_q  <= '0;
      s1Exp_q   <= '0;
    end else if (adv1) begin
      s1Valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1Sign_q <= bus.in_sign;
        s1Prod_q <= bus.in_prod;
        s1Exp_q  <= $signed(bus.in_exp);
      end
    end
  end

  // Stage 2 registers the packed result. The result holds whenever the consumer stalls or enable is low.
  always_ff @(posedge clk) begin
    if (arst) begin
      s2Valid_q <= 1'b0;
      outSign_q <= 1'b0;
      outExp_q  <= '0;
      outFrac_q <= '0;
      outOvf_q  <= 1'b0;
      outUnf_q  <= 1'b0;
      outInx_q  <= 1'b0;
    end else if (adv2) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outSign_q <= outSign_d;
        outExp_q  <= outExp_d;
        outFrac_q <= outFrac_d;
        outOvf_q  <= outOvf_d;
        outUnf_q  <= outUnf_d;
        outInx_q  <= outInx_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Scoreboard bench for fp_norm_round_pipe (MW=23, EW=8).
// The reference model works on integer arithmetic and follows NORM_RNE_EN.
module tb_fp_norm_round_pipe;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        ovf;
    logic        unf;
    logic        inx;
  } resT;

  logic clk = 1'b0;
  logic arst;
  logic en;
  int   readyMode;
  int   checks   = 0;
  int   failures = 0;
  resT  expQ[$];

  fp_norm_round_pipe_if #(.MW(23), .EW(8)) bus();

  fp_norm_round_pipe #(.MW(23), .EW(8)) dut (
    .clk  (clk),
    .arst (arst),
    .en   (en),
    .bus  (bus)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Reference result computed from the value of the product.
  function automatic resT model(input logic sgn, input logic [47:0] prod, input logic signed [9:0] x);
    resT    r;
    longint p;
    longint sig;
    longint rem;
    longint half;
    int     e;
    int     sh;
    bit     up;
    r      = '0;
    r.sign = sgn;
    p      = longint'(prod);
    e      = int'(x);
    if (p == 0) return r;
    if (p >= (64'sd1 <<< 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    sig  = p >>> sh;
    rem  = p & ((64'sd1 <<< sh) - 1);
    half = 64'sd1 <<< (sh - 1);
`ifdef NORM_RNE_EN
    up = (rem > half) || (rem == half && sig[0]);
`else
    up = 1'b0;
`endif
    if (up) sig = sig + 1;
    if (sig == (64'sd1 <<< 24)) begin
      sig = sig >>> 1;
      e   = e + 1;
    end
    if (e >= 255) begin
      r.exp = 8'hFF;
      r.ovf = 1'b1;
      r.inx = 1'b1;
    end else if (e <= 0) begin
      r.unf = 1'b1;
      r.inx = 1'b1;
    end else begin
      r.exp  = 8'(e);
      r.frac = 23'(sig & 64'sh7FFFFF);
      r.inx  = (rem != 0);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  // Offer one beat and wait until the DUT accepts it; the expected result is queued at acceptance.
  task automatic applyStimulus(input logic sgn, input logic [47:0] prod, input logic signed [9:0] x);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_sign  = sgn;
    bus.in_prod  = prod;
    bus.in_exp   = x;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        expQ.push_back(model(sgn, prod, x));
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          checks++;
          failures++;
          $display("[TB] FAIL accept_timeout: in_ready stuck at %b, required 1", bus.in_ready);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic randomBeat();
    logic [23:0]        a;
    logic [23:0]        b;
    logic [47:0]        p;
    logic signed [9:0]  x;
    logic               s;
    a = 24'h800000 | 24'($urandom() & 32'h7FFFFF);
    b = 24'h800000 | 24'($urandom() & 32'h7FFFFF);
    if ($urandom_range(3, 0) == 0) a = a & 24'hFFF000;
    if ($urandom_range(3, 0) == 0) b = b & 24'hFFF000;
    p = 48'(a) * 48'(b);
    if ($urandom_range(19, 0) == 0) p = '0;
    x = 10'(int'($urandom_range(330, 0)) - 40);
    s = 1'($urandom());
    applyStimulus(s, p, x);
  endtask

  task automatic waitDrained();
    for (int i = 0; i < 2000 && (expQ.size() != 0 || bus.out_valid === 1'b1); i++) @(posedge clk);
    checkOutput("drain", 64'(expQ.size()), 64'd0);
  endtask

  // Consumer-side ready generator. Mode 0 holds ready low, mode 1 holds it high, mode 2 randomizes it.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (readyMode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // Monitor: pop and compare on every output transfer, and require held outputs during stalls or freezes.
  initial begin
    logic holdPrev;
    resT  prevVal;
    resT  act;
    resT  want;
    holdPrev = 1'b0;
    prevVal  = '0;
    forever begin
      @(negedge clk);
      act = {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_ovf, bus.out_unf, bus.out_inx};
      if (holdPrev) begin
        checkOutput("stall_hold", {31'd0, bus.out_valid, 32'(act)}, {31'd0, 1'b1, 32'(prevVal)});
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && en === 1'b1 && arst === 1'b0) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: got %h with no result outstanding", act);
        end else begin
          want = expQ.pop_front();
          checkOutput("result", 64'(act), 64'(want));
        end
      end
      holdPrev = (bus.out_valid === 1'b1) && !(en === 1'b1 && bus.out_ready === 1'b1) && (arst === 1'b0);
      prevVal  = act;
    end
  end

  // Main sequence: reset, directed cases, backpressure, reset flush, enable freeze and random traffic.
  initial begin
    logic [47:0] bp [4];
    int          idx;
    logic [47:0] p;

    arst         = 1'b1;
    en           = 1'b1;
    readyMode    = 1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_prod  = '0;
    bus.in_exp   = '0;

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("reset_out_word",
                64'({bus.out_sign, bus.out_exp, bus.out_frac, bus.out_ovf, bus.out_unf, bus.out_inx}), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;

    applyStimulus(1'b0, 48'h9000_0000_0000, 10'sd127);
    p = {2'b01, 23'h000001, 1'b1, 22'b0};
    applyStimulus(1'b0, p, 10'sd100);
    p = {2'b01, 23'h000000, 1'b1, 22'b0};
    applyStimulus(1'b1, p, 10'sd100);
    p = {2'b01, {23{1'b1}}, 1'b1, 22'h1};
    applyStimulus(1'b0, p, 10'sd100);
    applyStimulus(1'b1, 48'h8000_0000_0000, 10'sd254);
    applyStimulus(1'b0, 48'h4000_0000_0000, 10'sd0);
    applyStimulus(1'b1, 48'h0, 10'sd50);
    applyStimulus(1'b0, 48'hFFFF_FFFF_FFFF, -10'sd5);
    idle(1);
    waitDrained();

    // Backpressure: only two beats fit while the consumer is stalled.
    readyMode = 0;
    bp[0] = 48'h9000_0000_0000;
    bp[1] = 48'h4800_0000_1234;
    bp[2] = 48'hC123_4567_89AB;
    bp[3] = 48'h5FFF_FFC0_0000;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_prod  = bp[idx];
      bus.in_exp   = 10'sd120;
      @(negedge clk);
      if (bus.in_ready === 1'b1 && idx < 4) begin
        expQ.push_back(model(1'b0, bp[idx], 10'sd120));
        idx++;
      end
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
    readyMode = 1;
    applyStimulus(1'b0, bp[2], 10'sd120);
    applyStimulus(1'b0, bp[3], 10'sd120);
    idle(1);
    waitDrained();

    // Reset with two beats in flight: both must vanish.
    readyMode = 0;
    applyStimulus(1'b1, 48'h9000_0000_0000, 10'sd60);
    applyStimulus(1'b0, 48'h6000_0000_0000, 10'sd61);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    arst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_word",
                64'({bus.out_sign, bus.out_exp, bus.out_frac, bus.out_ovf, bus.out_unf, bus.out_inx}), 64'd0);
    readyMode = 1;

    // Random traffic with a three-cycle enable freeze in the middle.
    readyMode = 2;
    for (int n = 0; n < 160; n++) begin
      if (n == 80) begin
        @(posedge clk); #1;
        en           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = 48'hABCD_EF01_2345;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("freeze_in_ready", 64'(bus.in_ready), 64'd0);
          if (k < 2) begin
            @(posedge clk); #1;
          end
        end
        @(posedge clk); #1;
        en           = 1'b1;
        bus.in_valid = 1'b0;
      end
      randomBeat();
      if ($urandom_range(7, 0) == 0) idle(1);
    end
    idle(1);
    readyMode = 1;
    waitDrained();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_norm_round_pipe.md
# fp_norm_round_pipe

- Parametrised successor to the multiplier normalizer.
- Takes the raw significand product, biased exponent sum and sign from the multiply datapath, then normalizes, rounds and range-checks the result.
- Two-stage pipeline with a valid/ready handshake and a global enable.
- Sits between the significand multiplier and the result packer, and produces a packed IEEE-style sign/exponent/fraction plus exception flags.

## Interface
Parameters:
- MW, 23: fraction width (hidden bit excluded); product width PW = 2*MW+2
- EW, 8: result exponent width; exponent input is EW+2 bits, two's complement, already bias-corrected

Ports:
- clk  in  1  clock, all state on rising edge
- arst  in  1  reset, synchronous, active-high
- en  in  1  global enable; when 0 no register updates, in_ready forced 0
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_sign  in  1  product sign
- in_prod  in  PW  unsigned significand product, 1.x * 1.x
- in_exp  in  EW+2  signed biased exponent sum
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sign  out  1  result sign
- out_exp  out  EW  result biased exponent
- out_frac  out  MW  result fraction
- out_ovf / out_unf / out_inx  out  1 each  overflow, underflow, inexact flags

## Operation
- Stage 1 registers in_sign, in_prod, in_exp on acceptance (in_valid & in_ready); sets s1_valid.
- Stage 2 computes the normalize/round/range result from the stage-1 registers and registers it into the out_* registers; sets s2_valid (= out_valid).
- Normalize:
  - If prod[PW-1]=1: frac = prod[PW-2 -: MW], guard = prod[PW-2-MW], sticky = OR(prod[PW-3-MW:0]), e = exp+1.
  - Else: frac = prod[PW-3 -: MW], guard = prod[PW-3-MW], sticky = OR of the bits below, e = exp.
- Round (see Configuration): increment frac. If frac was all ones, frac becomes 0 and e += 1.
- Arithmetic width: e is computed in EW+2 bits signed; no truncation before the range check.
- Range check, in priority order:
  - prod==0 → exp=0, frac=0, no flags.
  - e ≥ 2^EW−1 → exp all ones, frac=0, ovf=1, inx=1.
  - e ≤ 0 → exp=0, frac=0, unf=1, inx=1 (flush-to-zero, no subnormals).
  - Otherwise → exp=e[EW-1:0], inx=guard|sticky.
- Sign passes through unchanged in all cases, including zero and inf.

## Timing
- Handshake:
  - adv2 = en & (!s2_valid | out_ready)
  - adv1 = en & (!s1_valid | adv2)
  - in_ready = adv1
- Throughput: one beat per cycle with out_ready held high.
- Latency: accepted at edge N → out_valid at edge N+2 when unstalled.
- Stall: while out_valid & !out_ready, all out_* hold stable. Stage 1 fills, then in_ready drops.
- Simultaneous out handshake and new stage-1 data: the new result loads the same cycle; no bubble.
- en=0: full freeze; out_valid and out_* hold; in_ready=0 irrespective of other inputs.
- Reset, taken on the edge where arst=1:
  - s1_valid=0, out_valid=0, all out_* = 0, in_ready = 0 during that cycle.
  - In-flight beats are discarded, including mid-stall.
  - Reset overrides en.

## Configuration
- NORM_RNE_EN defined: round-to-nearest-even; increment when guard & (sticky | frac[0]).
- NORM_RNE_EN undefined: truncation.
  - Never increments; carry path unused.
  - inx still reports guard|sticky.
  - Matches the legacy normalizer's datapath results.

## Test plan
All scenarios use MW=23, EW=8, NORM_RNE_EN defined unless stated.
- 1.5×1.5: prod=48'h9000_0000_0000, exp=127, sign=0 → two cycles later exp=128, frac=23'h100000, no flags.
- RNE tie:
  - prod={2'b01, 23'h000001, 1'b1, 22'b0}, exp=100 → frac=23'h000002, inx=1.
  - Same with frac field 23'h000000 → frac=0, inx=1.
  - Without NORM_RNE_EN both cases truncate.
- Round carry: prod={2'b01, {23{1'b1}}, 1'b1, 22'h1}, exp=100 → exp=101, frac=0, inx=1.
- Range:
  - prod[47]=1, exp=254 → exp=8'hFF, frac=0, ovf=1.
  - exp=0, prod[47]=0 → exp=0, unf=1.
  - prod=0 → all zero, no flags.
- Backpressure: 4 back-to-back beats with out_ready=0 → in_ready drops after 2 accepted and out_* stable. Raising out_ready drains the results in order, one per cycle.
- Reset and enable:
  - arst pulsed with 2 beats in flight → out_valid=0 next cycle, no stale results later.
  - en=0 for 3 cycles mid-stream → state frozen, then resumes without loss.
